// File: rtl/hoplite_packet_assembler.sv
// hoplite_packet_assembler
// Gathers per-field network writes from a processor node into a staging
// register, packs them into one packet word on the commit strobe, and queues
// packets in a small FIFO that feeds the Hoplite router injection port.
//
// Handshake: a packet moves to the router in any cycle where packet_out_valid
// and packet_out_ready are both 1. packet_out_valid never drops without such
// a transfer, and packet_out stays stable while it waits. message_out_ready
// tells the node a commit will be accepted (FIFO not full). A commit at full
// still succeeds if the router accepts a packet in that same cycle.
module hoplite_packet_assembler #(
  parameter int COORD_BITS           = 1,
  parameter int MULTICAST_GROUP_BITS = 1,
  parameter int MATRIX_TYPE_BITS     = 1,
  parameter int MATRIX_COORD_BITS    = 8,
  parameter int MATRIX_ELEMENT_BITS  = 32,
  parameter int FIFO_DEPTH           = 4,
  parameter int PACKET_BITS          = 2*COORD_BITS + MULTICAST_GROUP_BITS + 2 +
                                       MATRIX_TYPE_BITS + 2*MATRIX_COORD_BITS +
                                       MATRIX_ELEMENT_BITS
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [COORD_BITS-1:0]           x_coord_in,
  input  logic                            x_coord_in_valid,
  input  logic [COORD_BITS-1:0]           y_coord_in,
  input  logic                            y_coord_in_valid,
  input  logic [MULTICAST_GROUP_BITS-1:0] multicast_group_in,
  input  logic                            multicast_group_in_valid,
  input  logic                            done_flag_in,
  input  logic                            done_flag_in_valid,
  input  logic                            result_flag_in,
  input  logic                            result_flag_in_valid,
  input  logic [MATRIX_TYPE_BITS-1:0]     matrix_type_in,
  input  logic                            matrix_type_in_valid,
  input  logic [MATRIX_COORD_BITS-1:0]    matrix_x_coord_in,
  input  logic                            matrix_x_coord_in_valid,
  input  logic [MATRIX_COORD_BITS-1:0]    matrix_y_coord_in,
  input  logic                            matrix_y_coord_in_valid,
  input  logic [MATRIX_ELEMENT_BITS-1:0]  matrix_element_in,
  input  logic                            matrix_element_in_valid,
  input  logic                            packet_complete_in,
  output logic                            message_out_ready,
  output logic [PACKET_BITS-1:0]          packet_out,
  output logic                            packet_out_valid,
  input  logic                            packet_out_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            drop_error,
  output logic [15:0]                     packets_sent
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam logic [CNT_BITS-1:0] DEPTH_CNT = CNT_BITS'(FIFO_DEPTH);

  // Staging register, one per field
  logic [COORD_BITS-1:0]           st_x, st_y;
  logic [MULTICAST_GROUP_BITS-1:0] st_group;
  logic                            st_done, st_result;
  logic [MATRIX_TYPE_BITS-1:0]     st_type;
  logic [MATRIX_COORD_BITS-1:0]    st_mx, st_my;
  logic [MATRIX_ELEMENT_BITS-1:0]  st_elem;

  // Field values after same-cycle write bypass
  logic [COORD_BITS-1:0]           bp_x, bp_y;
  logic [MULTICAST_GROUP_BITS-1:0] bp_group;
  logic                            bp_done, bp_result;
  logic [MATRIX_TYPE_BITS-1:0]     bp_type;
  logic [MATRIX_COORD_BITS-1:0]    bp_mx, bp_my;
  logic [MATRIX_ELEMENT_BITS-1:0]  bp_elem;
  logic [PACKET_BITS-1:0]          packed_word;

  // FIFO state
  logic [PACKET_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_BITS-1:0]    rd_ptr, wr_ptr;
  logic [CNT_BITS-1:0]    count;
  logic                   push, pop;

  // Bypass: a field written in the commit cycle wins over its staged value
  always_comb begin
    bp_x      = x_coord_in_valid        ? x_coord_in         : st_x;
    bp_y      = y_coord_in_valid        ? y_coord_in         : st_y;
    bp_group  = multicast_group_in_valid ? multicast_group_in : st_group;
    bp_done   = done_flag_in_valid      ? done_flag_in       : st_done;
    bp_result = result_flag_in_valid    ? result_flag_in     : st_result;
    bp_type   = matrix_type_in_valid    ? matrix_type_in     : st_type;
    bp_mx     = matrix_x_coord_in_valid ? matrix_x_coord_in  : st_mx;
    bp_my     = matrix_y_coord_in_valid ? matrix_y_coord_in  : st_my;
    bp_elem   = matrix_element_in_valid ? matrix_element_in  : st_elem;
    packed_word = {bp_x, bp_y, bp_group, bp_done, bp_result, bp_type,
                   bp_mx, bp_my, bp_elem};
  end

  // Staging fields load on their strobes; the bypass values already encode that
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st_x      <= '0;
      st_y      <= '0;
      st_group  <= '0;
      st_done   <= 1'b0;
      st_result <= 1'b0;
      st_type   <= '0;
      st_mx     <= '0;
      st_my     <= '0;
      st_elem   <= '0;
    end else begin
      st_x      <= bp_x;
      st_y      <= bp_y;
      st_group  <= bp_group;
      st_done   <= bp_done;
      st_result <= bp_result;
      st_type   <= bp_type;
      st_mx     <= bp_mx;
      st_my     <= bp_my;
      st_elem   <= bp_elem;
    end
  end

  // Push/pop decisions; a full FIFO still takes a commit when it pops
  always_comb begin
    pop  = packet_out_valid && packet_out_ready;
    push = packet_complete_in && ((count != DEPTH_CNT) || pop);
  end

  // Packet storage is not reset; only the pointers and count define contents
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= packed_word;
    end
  end

  // Pointers, occupancy, sticky drop flag and sent counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      drop_error   <= 1'b0;
      packets_sent <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_BITS'(1);
      end
      if (pop) begin
        rd_ptr       <= rd_ptr + PTR_BITS'(1);
        packets_sent <= packets_sent + 16'd1;
      end
      if (push && !pop) begin
        count <= count + CNT_BITS'(1);
      end else if (pop && !push) begin
        count <= count - CNT_BITS'(1);
      end
      if (packet_complete_in && !push) begin
        drop_error <= 1'b1;
      end
    end
  end

  // Outputs derive only from registered state
  always_comb begin
    packet_out        = mem[rd_ptr];
    packet_out_valid  = (count != '0);
    message_out_ready = (count != DEPTH_CNT);
    fifo_count        = count;
  end

endmodule

// File: tb/tb_hoplite_packet_assembler.sv
// tb_hoplite_packet_assembler
// Directed scenarios plus randomized traffic, all checked every cycle against
// a queue-based reference model of the assembler.
module tb_hoplite_packet_assembler;

  localparam int PW    = 54;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        x_coord_in, x_coord_in_valid;
  logic        y_coord_in, y_coord_in_valid;
  logic        multicast_group_in, multicast_group_in_valid;
  logic        done_flag_in, done_flag_in_valid;
  logic        result_flag_in, result_flag_in_valid;
  logic        matrix_type_in, matrix_type_in_valid;
  logic [7:0]  matrix_x_coord_in, matrix_y_coord_in;
  logic        matrix_x_coord_in_valid, matrix_y_coord_in_valid;
  logic [31:0] matrix_element_in;
  logic        matrix_element_in_valid;
  logic        packet_complete_in;
  logic        message_out_ready;
  logic [PW-1:0] packet_out;
  logic        packet_out_valid;
  logic        packet_out_ready;
  logic [2:0]  fifo_count;
  logic        drop_error;
  logic [15:0] packets_sent;

  hoplite_packet_assembler dut (
    .clk(clk), .reset_n(reset_n),
    .x_coord_in(x_coord_in), .x_coord_in_valid(x_coord_in_valid),
    .y_coord_in(y_coord_in), .y_coord_in_valid(y_coord_in_valid),
    .multicast_group_in(multicast_group_in), .multicast_group_in_valid(multicast_group_in_valid),
    .done_flag_in(done_flag_in), .done_flag_in_valid(done_flag_in_valid),
    .result_flag_in(result_flag_in), .result_flag_in_valid(result_flag_in_valid),
    .matrix_type_in(matrix_type_in), .matrix_type_in_valid(matrix_type_in_valid),
    .matrix_x_coord_in(matrix_x_coord_in), .matrix_x_coord_in_valid(matrix_x_coord_in_valid),
    .matrix_y_coord_in(matrix_y_coord_in), .matrix_y_coord_in_valid(matrix_y_coord_in_valid),
    .matrix_element_in(matrix_element_in), .matrix_element_in_valid(matrix_element_in_valid),
    .packet_complete_in(packet_complete_in),
    .message_out_ready(message_out_ready),
    .packet_out(packet_out), .packet_out_valid(packet_out_valid),
    .packet_out_ready(packet_out_ready),
    .fifo_count(fifo_count), .drop_error(drop_error), .packets_sent(packets_sent)
  );

  // ---------------- scoreboard / model ----------------
  logic [PW-1:0] exp_q[$];
  bit          m_drop;
  int unsigned m_sent;
  logic        s_x, s_y, s_g, s_d, s_r, s_t;
  logic [7:0]  s_mx, s_my;
  logic [31:0] s_e;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model advances by one clock using the inputs currently applied
  task automatic model_step();
    logic bx, by, bg, bd, br, bt;
    logic [7:0] bmx, bmy;
    logic [31:0] be;
    logic [PW-1:0] pkt;
    bit do_pop, do_push;
    if (!reset_n) begin
      exp_q.delete();
      m_drop = 0; m_sent = 0;
      {s_x, s_y, s_g, s_d, s_r, s_t} = '0;
      s_mx = '0; s_my = '0; s_e = '0;
      return;
    end
    bx  = x_coord_in_valid        ? x_coord_in         : s_x;
    by  = y_coord_in_valid        ? y_coord_in         : s_y;
    bg  = multicast_group_in_valid ? multicast_group_in : s_g;
    bd  = done_flag_in_valid      ? done_flag_in       : s_d;
    br  = result_flag_in_valid    ? result_flag_in     : s_r;
    bt  = matrix_type_in_valid    ? matrix_type_in     : s_t;
    bmx = matrix_x_coord_in_valid ? matrix_x_coord_in  : s_mx;
    bmy = matrix_y_coord_in_valid ? matrix_y_coord_in  : s_my;
    be  = matrix_element_in_valid ? matrix_element_in  : s_e;
    pkt = {bx, by, bg, bd, br, bt, bmx, bmy, be};
    do_pop  = (exp_q.size() != 0) && packet_out_ready;
    do_push = packet_complete_in && ((exp_q.size() < DEPTH) || do_pop);
    if (do_pop) begin
      void'(exp_q.pop_front());
      m_sent = (m_sent + 1) % 65536;
    end
    if (do_push) exp_q.push_back(pkt);
    else if (packet_complete_in) m_drop = 1;
    s_x = bx; s_y = by; s_g = bg; s_d = bd; s_r = br; s_t = bt;
    s_mx = bmx; s_my = bmy; s_e = be;
  endtask

  task automatic check_outputs();
    check_val("fifo_count", 64'(fifo_count), 64'(exp_q.size()));
    check_val("valid", 64'(packet_out_valid), 64'(exp_q.size() != 0));
    check_val("msg_ready", 64'(message_out_ready), 64'(exp_q.size() != DEPTH));
    check_val("drop_error", 64'(drop_error), 64'(m_drop));
    check_val("packets_sent", 64'(packets_sent), 64'(m_sent));
    if (exp_q.size() != 0) check_val("packet_out", 64'(packet_out), 64'(exp_q[0]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    {x_coord_in_valid, y_coord_in_valid, multicast_group_in_valid, done_flag_in_valid,
     result_flag_in_valid, matrix_type_in_valid, matrix_x_coord_in_valid,
     matrix_y_coord_in_valid, matrix_element_in_valid, packet_complete_in} = '0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
    clear_inputs();
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
    reset_n = 1'b1;
  endtask

  task automatic write_elem_commit(input logic [31:0] e);
    matrix_element_in = e;
    matrix_element_in_valid = 1'b1;
    packet_complete_in = 1'b1;
  endtask

  task automatic randomize_inputs();
    x_coord_in = 1'($urandom);         x_coord_in_valid = ($urandom_range(3) == 0);
    y_coord_in = 1'($urandom);         y_coord_in_valid = ($urandom_range(3) == 0);
    multicast_group_in = 1'($urandom); multicast_group_in_valid = ($urandom_range(3) == 0);
    done_flag_in = 1'($urandom);       done_flag_in_valid = ($urandom_range(3) == 0);
    result_flag_in = 1'($urandom);     result_flag_in_valid = ($urandom_range(3) == 0);
    matrix_type_in = 1'($urandom);     matrix_type_in_valid = ($urandom_range(3) == 0);
    matrix_x_coord_in = 8'($urandom);  matrix_x_coord_in_valid = ($urandom_range(3) == 0);
    matrix_y_coord_in = 8'($urandom);  matrix_y_coord_in_valid = ($urandom_range(3) == 0);
    matrix_element_in = $urandom;      matrix_element_in_valid = ($urandom_range(2) == 0);
    packet_complete_in = ($urandom_range(2) == 0);
    packet_out_ready = ($urandom_range(1) == 0);
  endtask

  // ---------------- main sequence ----------------
  logic [PW-1:0] single_pkt;
  initial begin
    single_pkt = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h05, 8'h0A, 32'hDEADBEEF};
    x_coord_in = 0; y_coord_in = 0; multicast_group_in = 0; done_flag_in = 0;
    result_flag_in = 0; matrix_type_in = 0; matrix_x_coord_in = 0;
    matrix_y_coord_in = 0; matrix_element_in = 0; packet_out_ready = 1'b1;
    clear_inputs();
    do_reset(2);

    // Single packet
    x_coord_in = 1; y_coord_in = 0; multicast_group_in = 1; done_flag_in = 0;
    result_flag_in = 1; matrix_type_in = 1; matrix_x_coord_in = 8'h05;
    matrix_y_coord_in = 8'h0A; matrix_element_in = 32'hDEADBEEF;
    {x_coord_in_valid, y_coord_in_valid, multicast_group_in_valid, done_flag_in_valid,
     result_flag_in_valid, matrix_type_in_valid, matrix_x_coord_in_valid,
     matrix_y_coord_in_valid, matrix_element_in_valid} = '1;
    tick();
    check_val("single_not_yet_valid", 64'(packet_out_valid), 64'd0);
    packet_complete_in = 1'b1;
    tick();
    check_val("single_pkt", 64'(packet_out), 64'(single_pkt));
    check_val("single_valid", 64'(packet_out_valid), 64'd1);
    tick();
    check_val("single_gone", 64'(packet_out_valid), 64'd0);
    check_val("single_sent", 64'(packets_sent), 64'd1);

    // Sticky fields with same-cycle element bypass
    write_elem_commit(32'h7);
    tick();
    check_val("bypass_pkt", 64'(packet_out), 64'({single_pkt[PW-1:32], 32'h7}));
    tick();

    // Fill and overflow
    packet_out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      write_elem_commit(32'h100 + 32'(i));
      tick();
    end
    check_val("fill_count", 64'(fifo_count), 64'd4);
    check_val("fill_ready_low", 64'(message_out_ready), 64'd0);
    write_elem_commit(32'h999);
    tick();
    check_val("overflow_drop", 64'(drop_error), 64'd1);
    check_val("overflow_count", 64'(fifo_count), 64'd4);
    packet_out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check_val("drain_order", 64'(packet_out[31:0]), 64'(32'h100 + 32'(i)));
      tick();
    end
    check_val("drain_empty", 64'(packet_out_valid), 64'd0);

    // Full push plus pop
    do_reset(1);
    packet_out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      write_elem_commit(32'h200 + 32'(i));
      tick();
    end
    packet_out_ready = 1'b1;
    write_elem_commit(32'h2FF);
    tick();
    check_val("fullpp_count", 64'(fifo_count), 64'd4);
    check_val("fullpp_drop", 64'(drop_error), 64'd0);
    for (int i = 0; i < DEPTH; i++) tick();
    check_val("fullpp_last", 64'(packet_out_valid), 64'd0);

    // Reset mid-queue
    packet_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      write_elem_commit($urandom);
      tick();
    end
    check_val("preset_count", 64'(fifo_count), 64'd3);
    do_reset(1);
    check_val("rst_count", 64'(fifo_count), 64'd0);
    check_val("rst_valid", 64'(packet_out_valid), 64'd0);
    check_val("rst_msg_ready", 64'(message_out_ready), 64'd1);
    check_val("rst_sent", 64'(packets_sent), 64'd0);
    packet_complete_in = 1'b1;
    tick();
    check_val("rst_bare_pkt", 64'(packet_out), 64'd0);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      reset_n = ($urandom_range(299) != 0);
      tick();
    end
    reset_n = 1'b1;

    // Counter wrap: 65536 accepted packets
    do_reset(1);
    for (int i = 0; i < 65537; i++) begin
      packet_out_ready = 1'b1;
      packet_complete_in = 1'b1;
      tick();
    end
    check_val("wrap_sent", 64'(packets_sent), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
